// File: rtl/reload_counter_pkg.sv
// reload_counter_pkg: shared state encoding and direction constants for reload_counter
package reload_counter_pkg;
  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
endpackage

// File: rtl/reload_prescaler.sv
// reload_prescaler: divides enabled cycles by PRESCALE, one-cycle step on the last phase
module reload_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic clr_i,
  output logic step_o
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] cnt_q;
  assign step_o = en_i && (cnt_q == PW'(PRESCALE - 1));
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= step_o ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/reload_counter.sv
// reload_counter: up/down counter reloading from the last loaded value; RELOAD_CNT_PRESCALE_EN adds a prescaler
module reload_counter
  import reload_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dir_i,
  input  logic             oneshot_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             done_o
);
  logic [WIDTH-1:0] count_q, rld_q, count_d, term;
  state_t state_q, state_d;
  logic tc_q, step, adv, at_term;
`ifdef RELOAD_CNT_PRESCALE_EN
  reload_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en_i   (en_i && state_q == RUN),
    .clr_i  (load_i),
    .step_o (step)
  );
`else
  localparam int unused_prescale = PRESCALE;
  assign step = en_i;
`endif
  always_comb begin
    term = (dir_i == DIR_DOWN) ? '0 : '1;
    at_term = count_q == term;
    adv = step && state_q == RUN;
    count_d = load_i ? load_val_i :
              !adv ? count_q :
              at_term ? (oneshot_i ? count_q : rld_q) :
              (dir_i == DIR_DOWN) ? count_q - 1'b1 : count_q + 1'b1;
    state_d = load_i ? RUN : (adv && at_term && oneshot_i) ? DONE : state_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      count_q <= '0;
      rld_q <= '0;
      state_q <= RUN;
      tc_q <= 1'b0;
    end else begin
      count_q <= count_d;
      rld_q <= load_i ? load_val_i : rld_q;
      state_q <= state_d;
      tc_q <= !load_i && adv && at_term;
    end
  assign count_o = count_q;
  assign tc_o = tc_q;
  assign done_o = state_q == DONE;
endmodule

// File: tb/tb_reload_counter.sv
// tb_reload_counter: directed scenarios plus randomized run against a behavioural model (WIDTH=4)
module tb_reload_counter;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0, dir = 1'b0, os = 1'b0;
  logic [3:0] lv = '0;
  logic [3:0] count;
  logic tc, done;
  int n_checks = 0, n_pass = 0;
  int m_cnt = 0, m_rld = 0;
  bit m_done = 0, m_tc = 0;

  reload_counter #(.WIDTH(4), .PRESCALE(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .en_i       (en),
    .load_i     (load),
    .load_val_i (lv),
    .dir_i      (dir),
    .oneshot_i  (os),
    .count_o    (count),
    .tc_o       (tc),
    .done_o     (done)
  );

  always #5 clk = ~clk;

  // Model: plain modular arithmetic over the counter's value range
  task automatic tick();
    int term;
    @(posedge clk);
    if (!reset) begin
      m_tc = 0;
      term = dir ? 0 : 15;
      if (load) begin
        m_cnt = lv; m_rld = lv; m_done = 0;
      end else if (en && !m_done) begin
        if (m_cnt == term) begin
          m_tc = 1;
          if (os) m_done = 1; else m_cnt = m_rld;
        end else m_cnt = dir ? (m_cnt + 15) % 16 : (m_cnt + 1) % 16;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_cnt = 0; m_rld = 0; m_done = 0; m_tc = 0;
    #2;
  endtask

  task automatic test_reset();
    en = 1'b1;
    do_reset();
    tick();
    n_checks++;
    if ({count, tc, done} !== 6'b0) $display("FAIL reset: got count=%h tc=%b done=%b, want 0 0 0", count, tc, done);
    else n_pass++;
    #2 reset = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_free_run();
    en = 1'b1; dir = 1'b0; os = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      n_checks++;
      if ({count, tc, done} !== {4'(i % 16), i == 16, 1'b0})
        $display("FAIL free_run[%0d]: got count=%h tc=%b done=%b, want %h %b 0", i, count, tc, done, 4'(i % 16), i == 16);
      else n_pass++;
    end
  endtask

  task automatic test_load_reload();
    logic [3:0] exp;
    load = 1'b1; lv = 4'hA; en = 1'b1;
    tick();
    load = 1'b0;
    n_checks++;
    if ({count, tc} !== {4'hA, 1'b0}) $display("FAIL load: got count=%h tc=%b, want a 0", count, tc);
    else n_pass++;
    exp = 4'hA;
    for (int i = 0; i < 12; i++) begin
      tick();
      exp = (exp == 4'hF) ? 4'hA : exp + 4'd1;
      n_checks++;
      if ({count, tc, done} !== {exp, exp == 4'hA, 1'b0})
        $display("FAIL reload[%0d]: got count=%h tc=%b done=%b, want %h %b 0", i, count, tc, done, exp, exp == 4'hA);
      else n_pass++;
    end
  endtask

  task automatic test_down();
    logic [3:0] exp_seq [5] = '{4'd2, 4'd1, 4'd0, 4'd3, 4'd3};
    load = 1'b1; lv = 4'd3; dir = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en = (i != 4);
      tick();
      n_checks++;
      if ({count, tc} !== {exp_seq[i], i == 3})
        $display("FAIL down[%0d]: got count=%h tc=%b, want %h %b", i, count, tc, exp_seq[i], i == 3);
      else n_pass++;
    end
    en = 1'b1;
    tick();
    n_checks++;
    if (count !== 4'd2) $display("FAIL down_resume: got count=%h, want 2", count);
    else n_pass++;
    dir = 1'b0;
  endtask

  task automatic test_oneshot();
    logic [5:0] exp_seq [6] = '{{4'hE, 2'b00}, {4'hF, 2'b00}, {4'hF, 2'b11},
                                {4'hF, 2'b01}, {4'hF, 2'b01}, {4'hF, 2'b01}};
    load = 1'b1; lv = 4'hD; os = 1'b1; en = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({count, tc, done} !== exp_seq[i])
        $display("FAIL oneshot[%0d]: got {count,tc,done}=%h, want %h", i, {count, tc, done}, exp_seq[i]);
      else n_pass++;
    end
    load = 1'b1; lv = 4'd2;
    tick();
    load = 1'b0;
    n_checks++;
    if ({count, tc, done} !== {4'd2, 2'b00}) $display("FAIL oneshot_exit: got count=%h tc=%b done=%b, want 2 0 0", count, tc, done);
    else n_pass++;
    os = 1'b0;
  endtask

  task automatic test_simultaneous();
    load = 1'b1; lv = 4'hE; en = 1'b1;
    tick();
    load = 1'b0;
    tick();
    load = 1'b1; lv = 4'd5;
    tick();
    load = 1'b0;
    n_checks++;
    if ({count, tc} !== {4'd5, 1'b0}) $display("FAIL load_at_term: got count=%h tc=%b, want 5 0", count, tc);
    else n_pass++;
    load = 1'b1; lv = 4'hF;
    tick();
    load = 1'b0;
    tick();
    n_checks++;
    if ({count, tc} !== {4'hF, 1'b1}) $display("FAIL pre_reset_tc: got count=%h tc=%b, want f 1", count, tc);
    else n_pass++;
    do_reset();
    n_checks++;
    if ({count, tc, done} !== 6'b0) $display("FAIL async_reset: got count=%h tc=%b done=%b, want 0 0 0", count, tc, done);
    else n_pass++;
    #1 reset = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(3, 0) != 0;
      load = $urandom_range(11, 0) == 0;
      lv = 4'($urandom);
      if ($urandom_range(15, 0) == 0) dir = ~dir;
      if ($urandom_range(7, 0) == 0) os = ~os;
      tick();
      n_checks++;
      if ({count, tc, done} !== {4'(m_cnt), m_tc, m_done})
        $display("FAIL random[%0d]: got count=%h tc=%b done=%b, want %h %b %b", i, count, tc, done, 4'(m_cnt), m_tc, m_done);
      else n_pass++;
    end
    load = 1'b0; en = 1'b0;
  endtask

  task automatic test_prescaler();
    logic [3:0] exp_seq [7] = '{4'hE, 4'hE, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE};
    load = 1'b1; lv = 4'hE; en = 1'b1; dir = 1'b0; os = 1'b0;
    tick();
    load = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_checks++;
      if ({count, tc} !== {exp_seq[i], i == 5})
        $display("FAIL prescale[%0d]: got count=%h tc=%b, want %h %b", i, count, tc, exp_seq[i], i == 5);
      else n_pass++;
    end
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    n_checks++;
    if (count !== 4'hE) $display("FAIL prescale_clr: got count=%h, want e", count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
`ifdef RELOAD_CNT_PRESCALE_EN
    test_prescaler();
`else
    test_free_run();
    test_load_reload();
    test_down();
    test_oneshot();
    test_simultaneous();
    test_random();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
